// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and the IF/ID pipeline register record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 4096;
  localparam logic [31:0] PC_INCR    = 32'd4;

  // Reused verbatim by the decode stage.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        fault;
  } ifid_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_stage_pc_next_sel.sv
// ============================================================================
// Module      : pc_next_sel
// Description : Next-PC priority mux (branch > stall > +4) and fetch fault test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = mips_pkg::IMEM_BYTES
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam logic [31:0] C_LAST_WORD = 32'(IMEM_BYTES - 4);

  always_comb begin
    pc_plus4 = pc + PC_INCR;
    // A taken branch outranks stall so the redirect is never dropped.
    if (branch_taken) begin
      pc_next = branch_target;
    end else if (stall) begin
      pc_next = pc;
    end else begin
      pc_next = pc_plus4;
    end
    fault = (pc > C_LAST_WORD) || (pc[1:0] != 2'b00);
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : MIPS-32 IF stage - PC register, imem address, IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int unsigned IMEM_BYTES = mips_pkg::IMEM_BYTES,
  parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  output logic [31:0] PC_Read_address,
  input  logic [31:0] Instruction_In,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC_Plus4,
  output logic        IFID_Valid,
  output logic        Fetch_Fault
);

  logic [31:0] r_pc;
  ifid_t       r_ifid;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic        w_fault;

  pc_next_sel #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc_next_sel (
    .pc            (r_pc),
    .stall         (Stall),
    .branch_taken  (Branch_taken),
    .branch_target (Branch_target),
    .pc_next       (w_pc_next),
    .pc_plus4      (w_pc_plus4),
    .fault         (w_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_ifid <= '{instr: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0, fault: 1'b0};
    end else begin
      r_pc <= w_pc_next;
      // A taken branch squashes the delay-slot word currently being fetched.
      if (Flush || Branch_taken) begin
        r_ifid <= '{instr: NOP_WORD, pc_plus4: w_pc_plus4, valid: 1'b0, fault: 1'b0};
      end else if (!Stall) begin
        if (w_fault) begin
          r_ifid <= '{instr: NOP_WORD, pc_plus4: w_pc_plus4, valid: 1'b0, fault: 1'b1};
        end else begin
          r_ifid <= '{instr: Instruction_In, pc_plus4: w_pc_plus4, valid: 1'b1, fault: 1'b0};
        end
      end
    end
  end

  assign PC_Read_address  = r_pc;
  assign IFID_Instruction = r_ifid.instr;
  assign IFID_PC_Plus4    = r_ifid.pc_plus4;
  assign IFID_Valid       = r_ifid.valid;
  assign Fetch_Fault      = r_ifid.fault;

endmodule

`default_nettype wire
